// File: rtl/edp_pkg.sv
// Shared encodings for the EBOX data-path slice.
package edp_pkg;

    localparam int unsigned FM_WORDS_PER_BLOCK = 16;

    typedef enum logic [2:0] {
        AdAdd, AdSub, AdAnd, AdOr, AdXor, AdPassA, AdPassB, AdNotA
    } ad_op_e;

    typedef enum logic [1:0] {AdaAr, AdaArx, AdaMq, AdaVma} ada_sel_e;

    typedef enum logic [1:0] {AdbBr, AdbBrx, AdbFm, AdbArx} adb_sel_e;

    typedef enum logic [2:0] {
        ArlHold, ArlAd, ArlCache, ArlSh, ArlArmm, ArlFm, ArlArx, ArlZero
    } arl_sel_e;

    typedef enum logic [1:0] {ArxlHold, ArxlAd, ArxlCache, ArxlAr} arxl_sel_e;

    typedef enum logic [1:0] {MqHold, MqShl, MqShr, MqLoad} mq_sel_e;

    typedef enum logic [2:0] {
        DiagAr, DiagArx, DiagBr, DiagBrx, DiagMq, DiagFm, DiagAd, DiagZero
    } diag_sel_e;

endpackage

// File: rtl/edp_fm.sv
// Fast-memory array with optional per-word odd parity and sticky error flag.
// Parity storage and checking exist only when EDP_FM_PARITY_EN is defined.
module edp_fm
    import edp_pkg::*;
#(
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned FM_BLOCKS = 8
) (
    input  logic                         clk_edp_h,
    input  logic                         rst_l,
    input  logic [$clog2(FM_BLOCKS)-1:0] fm_block_h,
    input  logic [3:0]                   fm_adr_h,
    input  logic                         fm_write_l,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         check_en,
    input  logic                         clr_err,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         parity_ok,
    output logic                         parity_err
);

    localparam int unsigned Depth = FM_BLOCKS * FM_WORDS_PER_BLOCK;
    localparam int unsigned AddrW = $clog2(FM_BLOCKS) + 4;

    logic [WIDTH-1:0] mem_q [Depth];
    logic [AddrW-1:0] addr;
    logic             wr_en;

    assign addr    = {fm_block_h, fm_adr_h};
    assign wr_en   = rst_l && !fm_write_l;
    assign rd_data = mem_q[addr];

    // Contents survive reset; only the write strobe is gated by it.
    always_ff @(posedge clk_edp_h) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

`ifdef EDP_FM_PARITY_EN
    logic par_q [Depth];
    logic err_q, err_d;

    always_ff @(posedge clk_edp_h) begin
        if (wr_en) begin
            par_q[addr] <= ~^wr_data;
        end
    end

    assign parity_ok = ^{rd_data, par_q[addr]};

    always_comb begin
        err_d = err_q;
        if (check_en && !parity_ok) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_edp_h) begin
        if (!rst_l) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign parity_err = err_q;
`else
    logic unused_parity;
    assign unused_parity = ^{check_en, clr_err};
    assign parity_ok     = 1'b1;
    assign parity_err    = 1'b0;
`endif

endmodule

// File: rtl/edp_slice.sv
// EBOX data-path slice: AR/ARX/BR/BRX/MQ, A/B adder, FM and EBUS read-back.
// FM parity is enabled by defining EDP_FM_PARITY_EN.
module edp_slice
    import edp_pkg::*;
#(
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned FM_BLOCKS = 8
) (
    input  logic                         clk_edp_h,
    input  logic                         rst_l,
    input  logic [WIDTH-1:0]             cache_data_h,
    input  logic [WIDTH-1:0]             sh_h,
    input  logic [WIDTH-1:0]             armm_h,
    input  logic [WIDTH-1:0]             vma_held_or_pc_h,
    input  logic [2:0]                   ad_op_h,
    input  logic [1:0]                   ada_sel_h,
    input  logic                         ada_dis_h,
    input  logic [1:0]                   adb_sel_h,
    input  logic                         ad_cry_in_h,
    input  logic [2:0]                   arl_sel_h,
    input  logic                         ar_clr_h,
    input  logic [1:0]                   arxl_sel_h,
    input  logic                         br_load_h,
    input  logic                         brx_load_h,
    input  logic [1:0]                   mq_sel_h,
    input  logic                         mq_shin_l_h,
    input  logic                         mq_shin_r_h,
    input  logic [$clog2(FM_BLOCKS)-1:0] fm_block_h,
    input  logic [3:0]                   fm_adr_h,
    input  logic                         fm_write_l,
    input  logic                         ad_to_ebus_h,
    input  logic                         diag_read_h,
    input  logic [2:0]                   diag_sel_h,
    input  logic                         diag_clr_err_h,
    output logic [WIDTH-1:0]             ar_h,
    output logic [WIDTH-1:0]             arx_h,
    output logic [WIDTH-1:0]             br_h,
    output logic [WIDTH-1:0]             brx_h,
    output logic [WIDTH-1:0]             mq_h,
    output logic [WIDTH-1:0]             ad_h,
    output logic                         ad_cry_out_h,
    output logic                         ad_eq0_l,
    output logic [WIDTH-1:0]             ebus_d_h,
    output logic                         ebus_en_h,
    output logic                         fm_parity_h,
    output logic                         fm_parity_err_h
);

    logic [WIDTH-1:0] ar_q, ar_d, arx_q, arx_d, br_q, br_d, brx_q, brx_d, mq_q, mq_d;
    logic [WIDTH-1:0] fm_rd, ada, adb;
    logic [WIDTH:0]   sum;
    logic             check_en;

    assign check_en = (adb_sel_e'(adb_sel_h) == AdbFm) || (arl_sel_e'(arl_sel_h) == ArlFm);

    edp_fm #(
        .WIDTH    (WIDTH),
        .FM_BLOCKS(FM_BLOCKS)
    ) u_fm (
        .clk_edp_h (clk_edp_h),
        .rst_l     (rst_l),
        .fm_block_h(fm_block_h),
        .fm_adr_h  (fm_adr_h),
        .fm_write_l(fm_write_l),
        .wr_data   (ar_q),
        .check_en  (check_en),
        .clr_err   (diag_clr_err_h),
        .rd_data   (fm_rd),
        .parity_ok (fm_parity_h),
        .parity_err(fm_parity_err_h)
    );

    // Vector bit WIDTH-1 is the PDP-10 bit 0, so ordinary arithmetic ripples toward it.
    always_comb begin
        ada = '0;
        unique case (ada_sel_e'(ada_sel_h))
            AdaAr:  ada = ar_q;
            AdaArx: ada = arx_q;
            AdaMq:  ada = mq_q;
            AdaVma: ada = vma_held_or_pc_h;
        endcase
        if (ada_dis_h) begin
            ada = '0;
        end
        adb = '0;
        unique case (adb_sel_e'(adb_sel_h))
            AdbBr:  adb = br_q;
            AdbBrx: adb = brx_q;
            AdbFm:  adb = fm_rd;
            AdbArx: adb = arx_q;
        endcase
        sum = '0;
        unique case (ad_op_e'(ad_op_h))
            AdAdd:   sum = {1'b0, ada} + {1'b0, adb} + {{WIDTH{1'b0}}, ad_cry_in_h};
            AdSub:   sum = {1'b0, ada} + {1'b0, ~adb} + {{WIDTH{1'b0}}, ad_cry_in_h};
            AdAnd:   sum = {1'b0, ada & adb};
            AdOr:    sum = {1'b0, ada | adb};
            AdXor:   sum = {1'b0, ada ^ adb};
            AdPassA: sum = {1'b0, ada};
            AdPassB: sum = {1'b0, adb};
            AdNotA:  sum = {1'b0, ~ada};
        endcase
    end

    assign ad_h         = sum[WIDTH-1:0];
    assign ad_cry_out_h = sum[WIDTH];
    assign ad_eq0_l     = |sum[WIDTH-1:0];

    always_comb begin
        ar_d = ar_q;
        unique case (arl_sel_e'(arl_sel_h))
            ArlHold:  ar_d = ar_q;
            ArlAd:    ar_d = ad_h;
            ArlCache: ar_d = cache_data_h;
            ArlSh:    ar_d = sh_h;
            ArlArmm:  ar_d = armm_h;
            ArlFm:    ar_d = fm_rd;
            ArlArx:   ar_d = arx_q;
            ArlZero:  ar_d = '0;
        endcase
        if (ar_clr_h) begin
            ar_d = '0;
        end
        arx_d = arx_q;
        unique case (arxl_sel_e'(arxl_sel_h))
            ArxlHold:  arx_d = arx_q;
            ArxlAd:    arx_d = ad_h;
            ArxlCache: arx_d = cache_data_h;
            ArxlAr:    arx_d = ar_q;
        endcase
        br_d  = br_load_h ? ar_q : br_q;
        brx_d = brx_load_h ? arx_q : brx_q;
        mq_d  = mq_q;
        unique case (mq_sel_e'(mq_sel_h))
            MqHold: mq_d = mq_q;
            MqShl:  mq_d = {mq_q[WIDTH-2:0], mq_shin_l_h};
            MqShr:  mq_d = {mq_shin_r_h, mq_q[WIDTH-1:1]};
            MqLoad: mq_d = ad_h;
        endcase
    end

    always_ff @(posedge clk_edp_h) begin
        if (!rst_l) begin
            ar_q  <= '0;
            arx_q <= '0;
            br_q  <= '0;
            brx_q <= '0;
            mq_q  <= '0;
        end else begin
            ar_q  <= ar_d;
            arx_q <= arx_d;
            br_q  <= br_d;
            brx_q <= brx_d;
            mq_q  <= mq_d;
        end
    end

    assign ar_h  = ar_q;
    assign arx_h = arx_q;
    assign br_h  = br_q;
    assign brx_h = brx_q;
    assign mq_h  = mq_q;

    always_comb begin
        ebus_d_h = '0;
        if (diag_read_h) begin
            unique case (diag_sel_e'(diag_sel_h))
                DiagAr:   ebus_d_h = ar_q;
                DiagArx:  ebus_d_h = arx_q;
                DiagBr:   ebus_d_h = br_q;
                DiagBrx:  ebus_d_h = brx_q;
                DiagMq:   ebus_d_h = mq_q;
                DiagFm:   ebus_d_h = fm_rd;
                DiagAd:   ebus_d_h = ad_h;
                DiagZero: ebus_d_h = '0;
            endcase
        end else if (ad_to_ebus_h) begin
            ebus_d_h = ad_h;
        end
    end

    assign ebus_en_h = ad_to_ebus_h | diag_read_h;

endmodule

// File: doc/edp_slice.md
# edp_slice

Parametrised EBOX data-path slice: a WIDTH-bit section of the AR/ARX/BR/BRX/MQ registers, the A/B adder with ripple carry, a fast-memory (FM) array with per-word parity, and the EBUS read-back driver. Replaces the fixed 6-bit board slices. Slices are stacked by chaining `ad_cry_in_h`/`ad_cry_out_h` and the MQ shift links. Adds selectable MQ shifting and a sticky FM parity-error flag.

## Interface
- WIDTH, 6, bits per slice (2..36)
- FM_BLOCKS, 8, FM blocks of 16 words each; FM depth = FM_BLOCKS*16
- clk_edp_h  in  1  EDP clock; all state changes on rising edge
- rst_l  in  1  reset; synchronous, active-low
- cache_data_h, sh_h, armm_h, vma_held_or_pc_h  in  WIDTH  AR/ARX/ADA sources
- ad_op_h  in  3  adder function
- ada_sel_h  in  2  A source: 0 AR, 1 ARX, 2 MQ, 3 vma_held_or_pc_h
- ada_dis_h  in  1  force A = 0
- adb_sel_h  in  2  B source: 0 BR, 1 BRX, 2 FM read data, 3 ARX
- ad_cry_in_h  in  1  carry into slice LSB
- arl_sel_h  in  3  AR next: 0 hold, 1 AD, 2 cache, 3 SH, 4 ARMM, 5 FM, 6 ARX, 7 zero
- ar_clr_h  in  1  clear AR; overrides arl_sel_h
- arxl_sel_h  in  2  ARX next: 0 hold, 1 AD, 2 cache, 3 AR
- br_load_h, brx_load_h  in  1  BR<=AR, BRX<=ARX
- mq_sel_h  in  2  0 hold, 1 shift left, 2 shift right, 3 load AD
- mq_shin_l_h  in  1  bit entering MQ LSB on left shift
- mq_shin_r_h  in  1  bit entering MQ MSB on right shift
- fm_block_h  in  $clog2(FM_BLOCKS)  FM block
- fm_adr_h  in  4  FM word within block
- fm_write_l  in  1  write AR into FM (active-low)
- ad_to_ebus_h  in  1  drive AD on EBUS
- diag_read_h  in  1  diagnostic read enable
- diag_sel_h  in  3  0 AR, 1 ARX, 2 BR, 3 BRX, 4 MQ, 5 FM, 6 AD, 7 zero
- diag_clr_err_h  in  1  clear parity-error flag
- ar_h, arx_h, br_h, brx_h, mq_h  out  WIDTH  registers
- ad_h  out  WIDTH  adder result (combinational)
- ad_cry_out_h  out  1  carry out of slice MSB
- ad_eq0_l  out  1  low when ad_h == 0
- ebus_d_h  out  WIDTH  EBUS data, zero when not enabled
- ebus_en_h  out  1  ad_to_ebus_h | diag_read_h
- fm_parity_h  out  1  odd parity over FM read word + stored bit (1 = good)
- fm_parity_err_h  out  1  sticky parity error

## Operation
- ad_op_h: 0 A+B+cin; 1 A+~B+cin; 2 A&B; 3 A|B; 4 A^B; 5 A; 6 B; 7 ~A. Carry out valid only for ops 0/1, else 0. Arithmetic mod 2^WIDTH; MSB is bit 0 (PDP-10 order), carry ripples from bit WIDTH-1 toward bit 0.
- MQ left shift: MQ <= {MQ[1:WIDTH-1], mq_shin_l_h}; right: {mq_shin_r_h, MQ[0:WIDTH-2]}. Neighbours take mq_h MSB/LSB as shift-in.
- FM read asynchronous from {fm_block_h, fm_adr_h}; write on edge when fm_write_l=0, data = current AR (pre-edge), stored parity = ~^AR.
- Parity check active when adb_sel_h==2 or arl_sel_h==5 and FM word fails odd parity; sets fm_parity_err_h at next edge. diag_clr_err_h clears; set wins if both same edge.
- EBUS: diag_read_h has priority over ad_to_ebus_h.

## Timing
- Reset (rst_l=0 at edge): AR, ARX, BR, BRX, MQ, fm_parity_err_h = 0. FM contents not cleared. Reset beats every load/write in the same cycle; fm_write_l ignored during reset.
- All register loads: one edge latency; BR/BRX capture pre-edge AR/ARX, so AR and BR load in same cycle gives BR = old AR.
- FM read-during-write same address: old data that cycle, new data next cycle.
- Combinational path ad_cry_in_h -> ad_cry_out_h/ad_h/ad_eq0_l; no registers in carry chain.

## Configuration
- EDP_FM_PARITY_EN: defined -> parity bit stored per word, fm_parity_h and error flag as above. Undefined -> no parity storage, fm_parity_h = 1, fm_parity_err_h = 0, diag_clr_err_h ignored.

## Structure
- Package edp_pkg: enums for ad_op, ada/adb select, arl/arxl select, mq_sel, diag_sel; FM_WORDS_PER_BLOCK = 16.
- One sub-module edp_fm: FM array, parity generation/check; slice top holds registers, adder, muxes.

## Test plan
- Reset with AR preloaded 6'o77 -> all registers 0, fm_parity_err_h 0, FM word at block 0 addr 0 retained.
- AR=6'o12, BR=6'o05, ada 0, adb 0, op 0, cin 1 -> ad_h=6'o20, cry_out 0; op 1 cin 1 -> 6'o05, cry_out 1.
- Write AR=6'o52 to block 3 addr 7, read same cycle old value, next cycle 6'o52, fm_parity_h 1.
- Force stored parity bit flip (bench backdoor), adb_sel=2 -> fm_parity_err_h 1 next edge, stays until diag_clr_err_h.
- MQ=6'o40, mq_sel 1, shin 1 -> MQ=6'o01; mq_sel 2, shin 1 -> 6'o40.
- diag_read_h=1, diag_sel 4, ad_to_ebus_h=1 -> ebus_d_h=MQ, ebus_en_h 1; both low -> ebus_d_h 0.
